// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package bit_serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_full_adder.sv
// One-bit combinational full adder; the single arithmetic element reused every bit step.
module single_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cy_in,
    output logic sum,
    output logic cy_out
);

    assign sum    = a ^ b ^ cy_in;
    assign cy_out = (a & b) | (cy_in & (a ^ b));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder controller: latches operands on start, adds LSB first one bit per clock,
// and reports {cy_out,sum} with a one-cycle done pulse.
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-1:0] sumShift_q;
    logic             carry_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             bitSum_d;
    logic             bitCarry_d;
    logic             lastBit_d;

    single_bit_full_adder uFullAdder (
        .a      (aShift_q[0]),
        .b      (bShift_q[0]),
        .cy_in  (carry_q),
        .sum    (bitSum_d),
        .cy_out (bitCarry_d)
    );

    assign lastBit_d = (cnt_q == CW'(WIDTH - 1));

    // Handshake outputs are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            aShift_q   <= '0;
            bShift_q   <= '0;
            sumShift_q <= '0;
            carry_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        aShift_q   <= a;
                        bShift_q   <= b;
                        carry_q    <= cy_in;
                        cnt_q      <= '0;
                        sumShift_q <= '0;
                        state_q    <= RUN;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sumShift_q <= {bitSum_d, sumShift_q[WIDTH-1:1]};
                    aShift_q   <= aShift_q >> 1;
                    bShift_q   <= bShift_q >> 1;
                    carry_q    <= bitCarry_d;
                    // The counter wraps to zero on the last bit so it never exceeds WIDTH-1.
                    if (lastBit_d) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sum    = sumShift_q;
    assign cy_out = carry_q;

endmodule
